fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's synchronous FIFO among `NREQ` producers. Each producer offers packets on a valid/ready interface. The arbiter grants one producer at a time and forwards its beats to the FIFO write port, honouring `fifo_full`. A grant is held until the producer's last beat or a fairness cap, then passes to the next requester in round-robin order.

## Interface
- `NREQ`, 4: number of requesters; must be ≥2.
- `WIDTH`, 8: data width; equals the FIFO `width`.
- `MAX_BURST`, 4: maximum beats per grant; must be ≥1.
- `IDW`, `$clog2(NREQ)`: grant id width (derived).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NREQ`  per-requester beat valid.
- `req_last`  in  `NREQ`  per-requester end-of-packet flag, qualified by `req_valid`.
- `req_data`  in  `NREQ*WIDTH`  requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  `NREQ`  beat accepted when `req_valid[i] && req_ready[i]`.
- `fifo_full`  in  1  full flag from the FIFO.
- `fifo_wen`  out  1  FIFO write enable.
- `fifo_wdata`  out  `WIDTH`  FIFO write data.
- `grant_valid`  out  1  a grant is active (`BURST` state).
- `grant_id`  out  `IDW`  index of the current or most recent owner.

## Operation
- Two-state FSM: `IDLE`, `BURST`. Registered state: `state`, `grant_id`, `rr_ptr` (`IDW` bits), `beat_cnt` (`$clog2(MAX_BURST+1)` bits).
- **IDLE:**
  - Drive `req_ready=0` and `fifo_wen=0`.
  - If any `req_valid` is set, the winner is the first set bit scanning from index `rr_ptr` upward with wrap to 0.
  - Next cycle: `state=BURST`, `grant_id=winner`, `beat_cnt=0`.
  - If no `req_valid` is set, stay in `IDLE`.
- **BURST:**
  - `req_ready[grant_id] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wen = req_valid[grant_id] && !fifo_full`.
  - `fifo_wdata` = slice `grant_id` of `req_data`. It is combinational and is valid only when `fifo_wen=1`.
  - Each accepted beat increments `beat_cnt`.
  - Leave to `IDLE` when an accepted beat has `req_last[grant_id]=1`, or when the accepted beat makes `beat_cnt` reach `MAX_BURST`.
  - On leaving: `rr_ptr = (grant_id+1) mod NREQ`. The wrap uses an explicit compare, so it is correct for non-power-of-2 `NREQ`.
- The owner dropping `req_valid` mid-burst does not release the grant. The arbiter waits with `fifo_wen=0`.
- `fifo_full=1` stalls the burst. No beat is lost or duplicated, and `beat_cnt` is unchanged.
- Valid/ready rule: a requester holds `req_valid`, `req_data` and `req_last` stable until accepted. The arbiter never asserts `fifo_wen` while `fifo_full=1`.
- Requesters that raise `req_valid` during another requester's burst are considered only at the next `IDLE` arbitration.

## Timing
- **Reset** (`rst=1` at an edge):
  - `state=IDLE`, `rr_ptr=0`, `grant_id=0`, `beat_cnt=0`.
  - Outputs: `grant_valid=0`, `req_ready=0`, `fifo_wen=0`, `fifo_wdata=0` (forced 0 in `IDLE`).
- **Reset mid-burst:** the burst is aborted immediately. Beats already accepted stay in the FIFO. No partial-packet recovery.
- **Latency:**
  - `req_valid` rising in `IDLE` at cycle N → grant registered at edge N+1 → first beat can be accepted in cycle N+1 (`fifo_wen` high in the same cycle if `!fifo_full`).
  - Exactly one bubble cycle (`IDLE`) between consecutive grants.
- **Throughput:** one beat per cycle within a grant. Peak rate with `MAX_BURST=4` and continuous traffic is 4 beats per 5 cycles.
- `grant_valid` is high exactly when `state=BURST`.
- `grant_id` holds its last value while in `IDLE`.
- `req_ready` and `fifo_wen` are combinational from `fifo_full` and `req_valid`. There is no register stage.
- **Single-beat packet** (`req_last=1` on the first beat): `BURST` lasts one cycle if `fifo_full=0`.
- **`MAX_BURST` reached** with no `last`: the grant is released. The same requester competes again, but with the lowest round-robin priority.

## Test plan
- **Single requester:** after reset, `req_valid=4'b0100` with a 3-beat packet (`0x11`, `0x22`, `0x33`, `last` on the 3rd) → `grant_id=2`. `fifo_wen` high for 3 consecutive cycles starting 1 cycle after `valid`. The FIFO reads back `0x11`, `0x22`, `0x33`. `rr_ptr=3`.
- **Round-robin fairness:** all 4 requesters continuously valid with 1-beat packets → grant order 0,1,2,3,0,1. Every other cycle is an `IDLE` bubble.
- **Burst cap:** requester 1 sends a 6-beat packet, requester 3 is idle → beats 1–4 are written, one bubble, then beats 5–6 under a new grant to requester 1. Beats arrive in order.
- **Full stall:** 8-deep FIFO, requester 0 writes 10 beats with no reads → exactly 8 writes occur. `fifo_wen=0` and `req_ready=0` while full. After 2 reads, the remaining 2 beats are written with no loss or duplication.
- **Owner gap:** requester 2 drops `req_valid` for 3 cycles mid-packet while requester 0 is valid → the grant stays at 2 with no writes. Requester 0 is granted only after requester 2's `last`.
- **Reset mid-burst:** `rst` pulsed during beat 2 of 4 → the next cycle shows `grant_valid=0`, `fifo_wen=0`, `req_ready=0`. The first post-reset grant is the lowest valid index (`rr_ptr=0`).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// A grant lasts until the owner's last beat or MAX_BURST beats, with one IDLE bubble between grants.
module fifo_wr_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned IDW       = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wen,
   output logic [WIDTH-1:0]        fifo_wdata,
   output logic                    grant_valid,
   output logic [IDW-1:0]          grant_id
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam int unsigned IW = IDW + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic [IW-1:0]   cand;
   logic            owner_valid;
   logic            owner_last;
   logic [WIDTH-1:0] owner_data;
   logic            accept;
   logic [CW-1:0]   beat_inc;
   logic [IDW-1:0]  ptr_next;

   // Scan from rr_ptr upward; the extra bit in cand lets the wrap work for any NREQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + IW'(k);
         if (cand >= IW'(NREQ)) begin
            cand = cand - IW'(NREQ);
         end
         if (!win_found && req_valid[cand[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (grant_id_q == IDW'(k)) begin
            owner_valid = req_valid[k];
            owner_last  = req_last[k];
            owner_data  = req_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign accept   = (state_q == BURST) && owner_valid && !fifo_full;
   assign beat_inc = beat_cnt_q + 1'b1;
   assign ptr_next = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = BURST;
               grant_id_d = win_id;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            if (accept) begin
               beat_cnt_d = beat_inc;
               if (owner_last || (beat_inc == CW'(MAX_BURST))) begin
                  state_d    = IDLE;
                  rr_ptr_d   = ptr_next;
                  beat_cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Handshake outputs stay combinational so a beat can move in the first BURST cycle.
   always_comb begin
      req_ready  = '0;
      fifo_wen   = 1'b0;
      fifo_wdata = '0;
      if (state_q == BURST) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            req_ready[k] = (grant_id_q == IDW'(k)) && !fifo_full;
         end
         fifo_wen   = owner_valid && !fifo_full;
         fifo_wdata = owner_data;
      end
   end

   assign grant_valid = (state_q == BURST);
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, an 8-deep FIFO stub and a
// transaction-level arbitration model checked every cycle, plus directed literal scenarios.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int MAXB  = 4;
   localparam int IDW   = 2;
   localparam int DEPTH = 8;
   localparam int LOGN  = 8192;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [7:0] gap;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_last;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic                  fifo_wen;
   logic [WIDTH-1:0]      fifo_wdata;
   logic                  grant_valid;
   logic [IDW-1:0]        grant_id;

   fifo_wr_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAXB), .IDW(IDW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
      .fifo_wdata(fifo_wdata), .grant_valid(grant_valid), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   beat_t pq[NREQ][$];
   int n_err = 0, n_chk = 0;
   bit chk_en = 1'b0;
   int cyc = 0, fcnt = 0, rd_pct = 100, rd_force = 0;
   bit prev_gv = 1'b0;

   bit m_busy = 1'b0;
   int m_owner = 0, m_ptr = 0, m_cnt = 0;

   int wr_id[$], wr_data[$], wr_cyc[$], gs_id[$], gs_cyc[$];
   int gv_log[LOGN], wen_log[LOGN], rdy_log[LOGN], gid_log[LOGN], wd_log[LOGN];

   int exp_rr[6] = '{0, 1, 2, 3, 0, 1};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int qv(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += pq[i].size();
      return s;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() > 0 && pq[i][0].gap == 0) begin
            req_valid[i] = 1'b1;
            req_last[i]  = pq[i][0].last;
            req_data[i*WIDTH +: WIDTH] = pq[i][0].data;
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[i*WIDTH +: WIDTH] = '0;
         end
      end
      fifo_full = (fcnt >= DEPTH);
   endtask

   task automatic push_beat(input int i, input int d, input bit l, input int g);
      beat_t b;
      b.data = 8'(d);
      b.last = l;
      b.gap  = 8'(g);
      pq[i].push_back(b);
   endtask

   task automatic cycle();
      logic [NREQ-1:0] er, hs;
      logic            ew, wen_s, rst_s;
      logic [7:0]      ed, wd_s;
      bit              nb_busy, found;
      int              nb_owner, nb_ptr, nb_cnt, j, rd;
      beat_t           b;
      @(negedge clk);
      // What the arbiter must be doing this cycle, from the grant rules alone.
      er = '0;
      ew = 1'b0;
      ed = '0;
      if (m_busy) begin
         if (!fifo_full) er[m_owner] = 1'b1;
         ew = req_valid[m_owner] && !fifo_full;
         ed = req_data[m_owner*WIDTH +: WIDTH];
      end
      if (chk_en) begin
         chk("grant_valid", grant_valid, m_busy);
         chk("grant_id", grant_id, m_owner);
         chk("req_ready", req_ready, er);
         chk("fifo_wen", fifo_wen, ew);
         if (!m_busy || ew) chk("fifo_wdata", fifo_wdata, ed);
      end
      for (int i = 0; i < NREQ; i++) hs[i] = (req_valid[i] && req_ready[i]) === 1'b1;
      wen_s = fifo_wen;
      wd_s  = fifo_wdata;
      rst_s = rst;
      if (cyc < LOGN) begin
         gv_log[cyc]  = int'(grant_valid);
         wen_log[cyc] = int'(fifo_wen);
         rdy_log[cyc] = int'(req_ready);
         gid_log[cyc] = int'(grant_id);
         wd_log[cyc]  = int'(fifo_wdata);
      end
      if (grant_valid === 1'b1 && !prev_gv) begin
         gs_id.push_back(int'(grant_id));
         gs_cyc.push_back(cyc);
      end
      prev_gv = (grant_valid === 1'b1);

      nb_busy = m_busy; nb_owner = m_owner; nb_ptr = m_ptr; nb_cnt = m_cnt;
      if (rst) begin
         nb_busy = 1'b0; nb_owner = 0; nb_ptr = 0; nb_cnt = 0;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!found && req_valid[j]) begin
               found = 1'b1; nb_busy = 1'b1; nb_owner = j; nb_cnt = 0;
            end
         end
      end else if (ew) begin
         nb_cnt = m_cnt + 1;
         if (req_last[m_owner] || nb_cnt == MAXB) begin
            nb_busy = 1'b0;
            nb_ptr  = (m_owner + 1) % NREQ;
         end
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() > 0 && pq[i][0].gap != 0) begin
            b = pq[i][0];
            b.gap = b.gap - 8'd1;
            pq[i][0] = b;
         end
         if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      end
      if (wen_s === 1'b1) begin
         wr_id.push_back(int'(grant_id));
         wr_data.push_back(int'(wd_s));
         wr_cyc.push_back(cyc);
      end
      rd = 0;
      if (fcnt > 0) begin
         if (rd_force > 0) begin
            rd = 1; rd_force--;
         end else if ($urandom_range(99) < rd_pct) begin
            rd = 1;
         end
      end
      fcnt = fcnt + ((wen_s === 1'b1) ? 1 : 0) - rd;
      m_busy = nb_busy; m_owner = nb_owner; m_ptr = nb_ptr; m_cnt = nb_cnt;
      if (rst_s === 1'b1) chk_en = 1'b1;
      cyc++;
      drive_inputs();
   endtask

   task automatic run_cycles(input int n);
      repeat (n) cycle();
   endtask

   task automatic clear_logs();
      wr_id.delete(); wr_data.delete(); wr_cyc.delete();
      gs_id.delete(); gs_cyc.delete();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, c;
      rst = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      rst = 1'b0;
      drive_inputs();

      c = cyc;
      cycle();
      chk("rst_grant_valid", gv_log[c], 0);
      chk("rst_fifo_wen", wen_log[c], 0);
      chk("rst_req_ready", rdy_log[c], 0);
      chk("rst_fifo_wdata", wd_log[c], 0);
      chk("rst_grant_id", gid_log[c], 0);

      // Single requester, 3-beat packet
      clear_logs();
      rd_pct = 100;
      push_beat(2, 'h11, 0, 0);
      push_beat(2, 'h22, 0, 0);
      push_beat(2, 'h33, 1, 0);
      drive_inputs();
      n0 = cyc;
      run_cycles(8);
      chk("t1_nwrites", wr_data.size(), 3);
      chk("t1_d0", qv(wr_data, 0), 'h11);
      chk("t1_d1", qv(wr_data, 1), 'h22);
      chk("t1_d2", qv(wr_data, 2), 'h33);
      chk("t1_id", qv(wr_id, 0), 2);
      chk("t1_first_cyc", qv(wr_cyc, 0), n0 + 1);
      chk("t1_last_cyc", qv(wr_cyc, 2), n0 + 3);
      clear_logs();
      push_beat(0, 'h0A, 1, 0);
      push_beat(3, 'h3A, 1, 0);
      drive_inputs();
      run_cycles(8);
      chk("t1_ptr_first", qv(gs_id, 0), 3);
      chk("t1_ptr_second", qv(gs_id, 1), 0);

      // Round-robin with single-beat packets
      reset_pulse();
      clear_logs();
      fcnt = 0;
      for (int i = 0; i < NREQ; i++) begin
         push_beat(i, 16 * i + 1, 1, 0);
         push_beat(i, 16 * i + 2, 1, 0);
      end
      drive_inputs();
      n0 = cyc;
      run_cycles(20);
      for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), qv(gs_id, k), exp_rr[k]);
      for (int k = 0; k < 8; k++) chk($sformatf("t2_gcyc%0d", k), qv(gs_cyc, k), n0 + 1 + 2 * k);
      chk("t2_d0", qv(wr_data, 0), 'h01);
      chk("t2_d3", qv(wr_data, 3), 'h31);
      chk("t2_d4", qv(wr_data, 4), 'h02);

      // Burst cap at MAX_BURST
      reset_pulse();
      clear_logs();
      for (int k = 0; k < 6; k++) push_beat(1, 'h61 + k, k == 5, 0);
      drive_inputs();
      n0 = cyc;
      run_cycles(12);
      for (int k = 0; k < 6; k++) chk($sformatf("t3_d%0d", k), qv(wr_data, k), 'h61 + k);
      chk("t3_c3", qv(wr_cyc, 3), n0 + 4);
      chk("t3_c4", qv(wr_cyc, 4), n0 + 6);
      chk("t3_c5", qv(wr_cyc, 5), n0 + 7);
      chk("t3_g0", qv(gs_id, 0), 1);
      chk("t3_g1", qv(gs_id, 1), 1);

      // FIFO full stall, no reads
      reset_pulse();
      clear_logs();
      fcnt = 0;
      rd_pct = 0;
      for (int k = 0; k < 10; k++) push_beat(0, 'h80 + k, k == 9, 0);
      drive_inputs();
      run_cycles(30);
      chk("t4_writes_full", wr_data.size(), 8);
      chk("t4_stall_gv", gv_log[cyc-1], 1);
      chk("t4_stall_wen", wen_log[cyc-1], 0);
      chk("t4_stall_rdy", rdy_log[cyc-1], 0);
      rd_force = 2;
      run_cycles(15);
      chk("t4_writes_total", wr_data.size(), 10);
      for (int k = 0; k < 10; k++) chk($sformatf("t4_d%0d", k), qv(wr_data, k), 'h80 + k);

      // Owner drops valid mid-packet while requester 0 waits
      reset_pulse();
      clear_logs();
      fcnt = 0;
      rd_pct = 100;
      push_beat(2, 'h21, 0, 0);
      push_beat(2, 'h22, 0, 3);
      push_beat(2, 'h23, 0, 0);
      push_beat(2, 'h24, 1, 0);
      push_beat(0, 'h01, 1, 2);
      drive_inputs();
      n0 = cyc;
      run_cycles(15);
      for (int k = 2; k <= 4; k++) begin
         chk($sformatf("t5_gap_gv%0d", k), gv_log[n0+k], 1);
         chk($sformatf("t5_gap_wen%0d", k), wen_log[n0+k], 0);
      end
      chk("t5_g0", qv(gs_id, 0), 2);
      chk("t5_g1", qv(gs_id, 1), 0);
      chk("t5_d3", qv(wr_data, 3), 'h24);
      chk("t5_d4", qv(wr_data, 4), 'h01);
      chk("t5_c4", qv(wr_cyc, 4), n0 + 9);

      // Reset during beat 2 of 4
      reset_pulse();
      clear_logs();
      for (int k = 0; k < 4; k++) push_beat(3, 'h31 + k, k == 3, 0);
      push_beat(1, 'h1B, 1, 1);
      drive_inputs();
      n0 = cyc;
      run_cycles(2);
      rst = 1'b1;
      run_cycles(1);
      rst = 1'b0;
      run_cycles(10);
      chk("t6_gv_after", gv_log[n0+3], 0);
      chk("t6_wen_after", wen_log[n0+3], 0);
      chk("t6_rdy_after", rdy_log[n0+3], 0);
      chk("t6_g0", qv(gs_id, 0), 3);
      chk("t6_g1", qv(gs_id, 1), 1);
      chk("t6_d1", qv(wr_data, 1), 'h32);
      chk("t6_d2", qv(wr_data, 2), 'h1B);
      chk("t6_d4", qv(wr_data, 4), 'h34);

      // Random traffic, random FIFO drain, occasional reset
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) rd_pct = $urandom_range(30, 95);
         for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() < 4 && $urandom_range(7) == 0) begin
               int len;
               len = $urandom_range(1, 7);
               for (int k = 0; k < len; k++)
                  push_beat(i, $urandom_range(255), k == len - 1,
                            ($urandom_range(5) == 0) ? $urandom_range(1, 3) : 0);
            end
         end
         rst = ($urandom_range(599) == 0);
         drive_inputs();
         cycle();
      end
      rst = 1'b0;
      rd_pct = 100;
      drive_inputs();
      for (int g = 0; g < 2000 && pending() > 0; g++) cycle();
      chk("drain_pending", pending(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
